writeback: RTL and testbench
============================

WRITEBACK -- requirements
Module: writeback

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, value loaded into curr_pc on reset.
REQ-002 Parameter NUM_REGS, default 32, number of general registers (x0..x31).
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port in_valid  input  1  exec result present this cycle.
REQ-006 Port in_ready  output  1  writeback accepts a result this cycle.
REQ-007 Port in_rd  input  5  destination register index.
REQ-008 Port in_rd_we  input  1  write in_rd_value into in_rd.
REQ-009 Port in_rd_value  input  32  result value.
REQ-010 Port in_pc  input  32  PC of the retiring instruction.
REQ-011 Port in_pc_redirect  input  1  instruction supplies a non-sequential next PC (JAL, JALR, taken branch).
REQ-012 Port in_next_pc  input  32  target PC, valid when in_pc_redirect=1.
REQ-013 Port in_halt  input  1  instruction is EBREAK/ECALL; processor stops after it.
REQ-014 Port curr_general_reg  output  NUM_REGS x 32  architectural register file, read by exec/dmem.
REQ-015 Port curr_pc  output  32  architectural PC, read by fetch.
REQ-016 Port flush  output  1  kill all younger in-flight instructions upstream.
REQ-017 Port halted  output  1  processor stopped.
REQ-018 Port instret  output  64  retired-instruction count.

Function
REQ-019 Accept (retire) occurs on a rising edge where in_valid=1 and in_ready=1; no other edge changes architectural state except reset.
REQ-020 in_ready SHALL be 1 only in state RUN; combinational from state alone, never from in_valid.
REQ-021 On accept with in_rd_we=1 and in_rd!=0, curr_general_reg[in_rd] <= in_rd_value; all other registers unchanged.
REQ-022 Register x0 SHALL read 0 at all times; writes to x0 are discarded.
REQ-023 On accept, curr_pc <= in_pc_redirect ? {in_next_pc[31:1],1'b0} : in_pc + 32'h4 (modulo 2^32, 0xFFFF_FFFC+4 wraps to 0).
REQ-024 On accept, instret <= instret + 1, wrapping from 2^64-1 to 0.
REQ-025 Write results are visible on curr_general_reg and curr_pc the cycle after accept (latency 1).
REQ-026 FSM states: RUN, FLUSH, HALTED.
REQ-027 RUN -> FLUSH on accept with in_pc_redirect=1, in_halt=0, and masked target != in_pc+4.
REQ-028 RUN -> HALTED on accept with in_halt=1, regardless of redirect; the halting instruction still commits REQ-021..024.
REQ-029 RUN stays RUN on accept with no redirect, or redirect whose target equals in_pc+4, or when no accept occurs.
REQ-030 FLUSH -> RUN unconditionally after exactly one cycle; flush=1 only in FLUSH; in_valid during FLUSH is ignored.
REQ-031 HALTED is left only by reset; halted=1 only in HALTED; in_valid ignored.
REQ-032 in_valid=1 with in_ready=0 SHALL NOT change state; upstream holds its payload.

Reset
REQ-033 On rst=1 at a rising edge: state=RUN, curr_pc=RESET_PC, all registers=0, instret=0, flush=0, halted=0.
REQ-034 rst takes priority over a simultaneous accept; the in-flight instruction is discarded and not counted.
REQ-035 rst asserted in FLUSH or HALTED returns to RUN per REQ-033.

Structure
REQ-036 State enum wb_state_t (RUN, FLUSH, HALTED) and RESET_PC default constant SHALL live in package defs.
REQ-037 Register file SHALL be a sub-module regfile (one write port, flat read-all output, x0 hardwired zero); PC, FSM and instret stay in writeback.

Verification
REQ-038 Reset, then accept in_rd=5, we=1, value=0xDEAD_BEEF, in_pc=0x100 -> next cycle x5=0xDEAD_BEEF, curr_pc=0x104, instret=1, flush=0.
REQ-039 Accept in_rd=0, we=1, value=0x1234 -> x0 reads 0; instret increments.
REQ-040 Accept in_pc=0x200, redirect=1, next_pc=0x301 -> curr_pc=0x300, flush=1 for exactly one cycle, in_ready=0 that cycle, then RUN.
REQ-041 Redirect with next_pc=in_pc+4 (0x40 -> 0x44) -> curr_pc=0x44, no FLUSH cycle.
REQ-042 Accept in_halt=1, we=1, rd=3, value=7 -> x3=7, halted=1, in_ready=0 forever; further in_valid changes nothing; rst -> curr_pc=RESET_PC, halted=0.
REQ-043 Force instret=2^64-1 and curr_pc=0xFFFF_FFFC, accept sequential -> instret=0, curr_pc=0; rst together with in_valid -> nothing retired.

Source files
------------

// File: rtl/writeback_pkg.sv
// Shared definitions for the writeback stage.
// Holds the FSM state enum and default parameter constants.
package defs;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      FLUSH  = 2'd1,
      HALTED = 2'd2
   } wb_state_t;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam int          NUM_REGS_DEFAULT = 32;

endpackage

// File: rtl/writeback_if.sv
// Exec -> writeback result handshake.
// master drives the result payload, slave returns in_ready.
interface writeback_if;
   import defs::*;

   logic        in_valid;
   logic        in_ready;
   logic [4:0]  in_rd;
   logic        in_rd_we;
   logic [31:0] in_rd_value;
   logic [31:0] in_pc;
   logic        in_pc_redirect;
   logic [31:0] in_next_pc;
   logic        in_halt;

   modport master (
      output in_valid, in_rd, in_rd_we, in_rd_value,
      output in_pc, in_pc_redirect, in_next_pc, in_halt,
      input  in_ready
   );

   modport slave (
      input  in_valid, in_rd, in_rd_we, in_rd_value,
      input  in_pc, in_pc_redirect, in_next_pc, in_halt,
      output in_ready
   );

endinterface

// File: rtl/writeback_regfile.sv
// General register file: one write port, whole file readable.
// Ports: clk, rst, we/waddr/wdata write port, regs flat read-out.
module regfile
   import defs::*;
#(
   parameter int NUM_REGS = NUM_REGS_DEFAULT
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         we,
   input  logic [4:0]                   waddr,
   input  logic [31:0]                  wdata,
   output logic [NUM_REGS-1:0][31:0]    regs
);

   // x0 has no storage; it is a constant zero on the output
   logic [NUM_REGS-1:1][31:0] mem;

   always_ff @(posedge clk) begin
      if (rst) begin
         mem <= '0;
      end else begin
         for (int i = 1; i < NUM_REGS; i++) begin
            if (we && waddr == i[4:0])
               mem[i] <= wdata;
         end
      end
   end

   assign regs = {mem, 32'h0};

endmodule

// File: rtl/writeback.sv
// Writeback stage: retires exec results, owns PC, FSM and instret.
// Ports: clk, rst, io (result handshake), arch state outputs.
module writeback
   import defs::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          NUM_REGS = NUM_REGS_DEFAULT
) (
   input  logic                      clk,
   input  logic                      rst,
   writeback_if.slave                io,
   output logic [NUM_REGS-1:0][31:0] curr_general_reg,
   output logic [31:0]               curr_pc,
   output logic                      flush,
   output logic                      halted,
   output logic [63:0]               instret
);

   wb_state_t   state;
   wb_state_t   state_nx;
   logic [63:0] instret_q;
   logic        accept;
   logic [31:0] seq_pc;
   logic [31:0] tgt_pc;
   logic [31:0] nxt_pc;

   assign io.in_ready = (state == RUN);
   assign accept      = io.in_valid & io.in_ready;
   assign seq_pc      = io.in_pc + 32'h4;
   // jump targets are forced to halfword alignment
   assign tgt_pc      = io.in_next_pc & ~32'h1;
   assign nxt_pc      = io.in_pc_redirect ? tgt_pc : seq_pc;

   regfile #(
      .NUM_REGS (NUM_REGS)
   ) u_rf (
      .clk   (clk),
      .rst   (rst),
      .we    (accept & io.in_rd_we),
      .waddr (io.in_rd),
      .wdata (io.in_rd_value),
      .regs  (curr_general_reg)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         curr_pc   <= RESET_PC;
         instret_q <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            curr_pc   <= nxt_pc;
            instret_q <= instret_q + 64'd1;
         end
      end
   end

   always_comb begin
      state_nx = state;
      flush    = 1'b0;
      halted   = 1'b0;
      unique case (state)
         RUN: begin
            if (accept) begin
               if (io.in_halt)
                  state_nx = HALTED;
               // a redirect to the fall-through PC needs no flush
               else if (io.in_pc_redirect && tgt_pc != seq_pc)
                  state_nx = FLUSH;
            end
         end
         FLUSH: begin
            flush    = 1'b1;
            state_nx = RUN;
         end
         HALTED: begin
            halted = 1'b1;
         end
         default: state_nx = RUN;
      endcase
   end

   assign instret = instret_q;

endmodule

// File: tb/tb_writeback.sv
// Self-checking bench for writeback: directed cases plus random
// stimulus compared against a behavioural model every cycle.
module tb_writeback;

   logic                 clk;
   logic                 rst;
   logic [31:0][31:0]    curr_general_reg;
   logic [31:0]          curr_pc;
   logic                 flush;
   logic                 halted;
   logic [63:0]          instret;

   writeback_if io ();

   writeback dut (
      .clk              (clk),
      .rst              (rst),
      .io               (io.slave),
      .curr_general_reg (curr_general_reg),
      .curr_pc          (curr_pc),
      .flush            (flush),
      .halted           (halted),
      .instret          (instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   // behavioural model
   logic [31:0] m_regs [32];
   logic [31:0] m_pc;
   logic [63:0] m_instret;
   bit          m_flush_cycle;
   bit          m_stopped;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h @%0t", name, act, exp,
                  $time);
      end
   endtask

   task automatic chk_vec(input string name,
                          input logic [31:0][31:0] act,
                          input logic [31:0][31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         for (int i = 0; i < 32; i++)
            if (act[i] !== exp[i])
               $display("FAIL %s: x%0d got %h expected %h @%0t", name,
                        i, act[i], exp[i], $time);
      end
   endtask

   always @(posedge clk) begin
      logic [31:0] tgt;
      if (rst) begin
         foreach (m_regs[i]) m_regs[i] = 32'h0;
         m_pc          = 32'h0;
         m_instret     = 64'h0;
         m_flush_cycle = 1'b0;
         m_stopped     = 1'b0;
      end else if (m_flush_cycle) begin
         m_flush_cycle = 1'b0;
      end else if (!m_stopped && io.in_valid) begin
         if (io.in_rd_we && io.in_rd != 5'd0)
            m_regs[io.in_rd] = io.in_rd_value;
         tgt = {io.in_next_pc[31:1], 1'b0};
         m_pc = io.in_pc_redirect ? tgt : io.in_pc + 32'd4;
         m_instret = m_instret + 64'd1;
         if (io.in_halt)
            m_stopped = 1'b1;
         else if (io.in_pc_redirect && tgt != io.in_pc + 32'd4)
            m_flush_cycle = 1'b1;
      end
   end

   // single compare process, on the non-active edge
   always @(negedge clk) begin
      logic [31:0][31:0] exp_regs;
      if (chk_en) begin
         for (int i = 0; i < 32; i++) exp_regs[i] = m_regs[i];
         chk("in_ready", 64'(io.in_ready),
             64'(!m_flush_cycle && !m_stopped));
         chk("flush", 64'(flush), 64'(m_flush_cycle));
         chk("halted", 64'(halted), 64'(m_stopped));
         chk("curr_pc", 64'(curr_pc), 64'(m_pc));
         chk("instret", instret, m_instret);
         chk_vec("regs", curr_general_reg, exp_regs);
      end
   end

   task automatic drive(input bit v, input logic [4:0] rd,
                        input bit we, input logic [31:0] val,
                        input logic [31:0] pc, input bit redir,
                        input logic [31:0] npc, input bit halt);
      io.in_valid       = v;
      io.in_rd          = rd;
      io.in_rd_we       = we;
      io.in_rd_value    = val;
      io.in_pc          = pc;
      io.in_pc_redirect = redir;
      io.in_next_pc     = npc;
      io.in_halt        = halt;
   endtask

   task automatic idle();
      drive(0, 5'd0, 0, 32'h0, 32'h0, 0, 32'h0, 0);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic [31:0] pc;
      rst = 1'b1;
      idle();
      @(negedge clk);
      tick();
      rst = 1'b0;
      chk_en = 1'b1;
      chk("rst_pc", 64'(curr_pc), 64'h0);
      chk("rst_instret", instret, 64'h0);
      chk("rst_ready", 64'(io.in_ready), 64'h1);

      drive(1, 5'd5, 1, 32'hDEAD_BEEF, 32'h100, 0, 32'h0, 0);
      tick(); idle();
      chk("d1_x5", 64'(curr_general_reg[5]), 64'hDEAD_BEEF);
      chk("d1_pc", 64'(curr_pc), 64'h104);
      chk("d1_instret", instret, 64'd1);
      chk("d1_flush", 64'(flush), 64'h0);

      drive(1, 5'd0, 1, 32'h1234, 32'h104, 0, 32'h0, 0);
      tick(); idle();
      chk("d2_x0", 64'(curr_general_reg[0]), 64'h0);
      chk("d2_instret", instret, 64'd2);

      drive(1, 5'd1, 0, 32'h0, 32'h200, 1, 32'h301, 0);
      tick();
      chk("d3_pc", 64'(curr_pc), 64'h300);
      chk("d3_flush", 64'(flush), 64'h1);
      chk("d3_ready", 64'(io.in_ready), 64'h0);
      drive(1, 5'd6, 1, 32'h55, 32'h300, 0, 32'h0, 0);
      tick(); idle();
      chk("d3_flush_end", 64'(flush), 64'h0);
      chk("d3_ready_back", 64'(io.in_ready), 64'h1);
      chk("d3_ignored_x6", 64'(curr_general_reg[6]), 64'h0);
      chk("d3_ignored_cnt", instret, 64'd3);

      drive(1, 5'd0, 0, 32'h0, 32'h40, 1, 32'h44, 0);
      tick(); idle();
      chk("d4_pc", 64'(curr_pc), 64'h44);
      chk("d4_flush", 64'(flush), 64'h0);

      drive(1, 5'd3, 1, 32'h7, 32'h50, 1, 32'h900, 1);
      tick();
      chk("d5_x3", 64'(curr_general_reg[3]), 64'h7);
      chk("d5_halted", 64'(halted), 64'h1);
      drive(1, 5'd3, 1, 32'h9, 32'h60, 0, 32'h0, 0);
      repeat (3) tick();
      chk("d5_x3_hold", 64'(curr_general_reg[3]), 64'h7);
      chk("d5_ready", 64'(io.in_ready), 64'h0);
      chk("d5_cnt_hold", instret, 64'd5);
      idle();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("d5_rst_pc", 64'(curr_pc), 64'h0);
      chk("d5_rst_halted", 64'(halted), 64'h0);

      force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
      m_instret = 64'hFFFF_FFFF_FFFF_FFFF;
      #1 release dut.instret_q;
      drive(1, 5'd0, 0, 32'h0, 32'hFFFF_FFFC, 0, 32'h0, 0);
      tick();
      chk("d6_wrap_cnt", instret, 64'h0);
      chk("d6_wrap_pc", 64'(curr_pc), 64'h0);
      drive(1, 5'd4, 1, 32'hABCD, 32'h80, 0, 32'h0, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      idle();
      chk("d6_rst_cnt", instret, 64'h0);
      chk("d6_rst_x4", 64'(curr_general_reg[4]), 64'h0);

      for (int n = 0; n < 3000; n++) begin
         pc = {$urandom(), 2'b00};
         pc = pc[31:0];
         drive($urandom_range(0, 3) != 0,
               5'($urandom_range(0, 31)),
               $urandom_range(0, 9) < 7,
               $urandom(),
               pc,
               $urandom_range(0, 9) < 3,
               ($urandom_range(0, 3) == 0) ? pc + 32'd4 : $urandom(),
               $urandom_range(0, 49) == 0);
         rst = halted ? ($urandom_range(0, 9) == 0)
                      : ($urandom_range(0, 99) == 0);
         tick();
      end
      rst = 1'b0;
      idle();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
